banked_register_file: RTL and testbench

Parametrised ARM register file, the successor to the flat 16-entry file.
- Adds ARM mode banking: FIQ R8–R14, IRQ R13–R14, SVC R13–R14.
- Two write ports with fixed priority, N parameterised read ports, optional write-to-read bypass, and a registered R15-write notification to the PC unit.
- Sits between decode/operand fetch and the writeback stage of the ARM datapath.

---
 rtl/arm_regfile_pkg.sv | 42 ++++
 rtl/arm_bank_map.sv | 28 ++
 rtl/banked_register_file.sv | 95 +++++++++
 tb/tb_banked_register_file.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_regfile_pkg.sv
// Shared definitions for the banked ARM register file: CPSR mode encodings,
// register banks, physical storage layout and the mode-to-bank decode.
package arm_regfile_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    typedef enum logic [1:0] {
        BANK_USR = 2'd0,
        BANK_FIQ = 2'd1,
        BANK_IRQ = 2'd2,
        BANK_SVC = 2'd3
    } bank_t;

    localparam int NUM_PHYS = 26;
    localparam int PHYS_W   = 5;

    // Physical slot of the first banked register of each privileged bank
    localparam logic [PHYS_W-1:0] FIQ_BASE = 5'd15;  // FIQ R8..R14
    localparam logic [PHYS_W-1:0] IRQ_BASE = 5'd22;  // IRQ R13..R14
    localparam logic [PHYS_W-1:0] SVC_BASE = 5'd24;  // SVC R13..R14

    // FORCE_USR overrides the mode; ABT, UND and undefined encodings use the user bank
    function automatic bank_t mode_to_bank(input logic [4:0] mode, input logic force_usr);
        bank_t bank;
        bank = BANK_USR;
        if (!force_usr) begin
            case (mode)
                MODE_FIQ:           bank = BANK_FIQ;
                MODE_IRQ:           bank = BANK_IRQ;
                MODE_SVC:           bank = BANK_SVC;
                MODE_USR, MODE_SYS: bank = BANK_USR;
                default:            bank = BANK_USR;
            endcase
        end
        return bank;
    endfunction

endpackage

// File: rtl/arm_bank_map.sv
// Combinational translation of a logical register number to a physical
// storage slot for a given bank. Logical R15 maps to slot 15 here, but the
// caller never uses that slot for R15 (reads return the PC, writes go to the
// PC unit).
module arm_bank_map
    import arm_regfile_pkg::*;
(
    input  bank_t              bank,
    input  logic [3:0]         addr,
    output logic [PHYS_W-1:0]  phys
);

    logic [PHYS_W-1:0] addr_ext;
    assign addr_ext = {1'b0, addr};

    // Identity into the user bank unless the bank shadows this register
    always_comb begin
        // NOTE: default assignment first so every path drives phys and no latch is inferred.
        phys = addr_ext;
        case (bank)
            BANK_FIQ: if (addr >= 4'd8 && addr <= 4'd14)  phys = addr_ext - 5'd8  + FIQ_BASE;
            BANK_IRQ: if (addr >= 4'd13 && addr <= 4'd14) phys = addr_ext - 5'd13 + IRQ_BASE;
            BANK_SVC: if (addr >= 4'd13 && addr <= 4'd14) phys = addr_ext - 5'd13 + SVC_BASE;
            default:  ;
        endcase
    end

endmodule

// File: rtl/banked_register_file.sv
// ARM register file with FIQ/IRQ/SVC banking, two prioritised write ports,
// NUM_READ combinational read ports, optional write-to-read bypass and a
// registered notification to the PC unit when R15 is written.
module banked_register_file
    import arm_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_READ = 3,
    parameter int BYPASS   = 1
)(
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [4:0]                 MODE,
    input  logic                       FORCE_USR,
    input  logic [4*NUM_READ-1:0]      RADDR,
    output logic [DATA_W*NUM_READ-1:0] RDATA,
    input  logic                       WE_A,
    input  logic [3:0]                 WA_A,
    input  logic [DATA_W-1:0]          WD_A,
    input  logic                       WE_B,
    input  logic [3:0]                 WA_B,
    input  logic [DATA_W-1:0]          WD_B,
    input  logic [DATA_W-1:0]          PROGCOUNT,
    output logic                       PC_WR,
    output logic [DATA_W-1:0]          PC_WDATA
);

    localparam logic [3:0] R15 = 4'hF;

    bank_t             eff_bank;
    logic [PHYS_W-1:0] phys_a;
    logic [PHYS_W-1:0] phys_b;
    logic              wr_a;
    logic              wr_b;
    logic              pc_a;
    logic              pc_b;
    logic [DATA_W-1:0] regs [NUM_PHYS];

    assign eff_bank = mode_to_bank(MODE, FORCE_USR);

    arm_bank_map u_map_a (.bank(eff_bank), .addr(WA_A), .phys(phys_a));
    arm_bank_map u_map_b (.bank(eff_bank), .addr(WA_B), .phys(phys_b));

    // Storage writes: R15 never reaches storage, and B is dropped when it
    // targets the same physical slot as A. Gated by reset so the bypass path
    // also reads zero while reset is held.
    assign wr_a = RESET_N && WE_A && (WA_A != R15);
    assign wr_b = RESET_N && WE_B && (WA_B != R15) && !(wr_a && (phys_a == phys_b));
    assign pc_a = WE_A && (WA_A == R15);
    assign pc_b = WE_B && (WA_B == R15);

    // Register storage update
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the storage array is reset explicitly because reads during and after reset must return 0.
            for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
        end else begin
            if (wr_a) regs[phys_a] <= WD_A;
            if (wr_b) regs[phys_b] <= WD_B;
        end
    end

    // One-cycle R15 write pulse to the PC unit; data holds between writes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PC_WR    <= 1'b0;
            PC_WDATA <= '0;
        end else begin
            PC_WR <= pc_a || pc_b;
            if (pc_a)      PC_WDATA <= WD_A;
            else if (pc_b) PC_WDATA <= WD_B;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [3:0]        raddr;
        logic [PHYS_W-1:0] rphys;
        logic [DATA_W-1:0] rd;

        assign raddr = RADDR[4*k +: 4];

        arm_bank_map u_map_r (.bank(eff_bank), .addr(raddr), .phys(rphys));

        // Read mux: PC for R15, else in-flight write data (bypass) or storage
        always_comb begin
            if (raddr == R15)                                 rd = PROGCOUNT;
            else if (BYPASS != 0 && wr_a && phys_a == rphys)  rd = WD_A;
            else if (BYPASS != 0 && wr_b && phys_b == rphys)  rd = WD_B;
            else                                              rd = regs[rphys];
        end

        assign RDATA[DATA_W*k +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file. Two instances share all
// inputs: one with bypass, one without. A bank/register-level reference model
// predicts every read and PC notification.
module tb_banked_register_file;

    localparam int DW = 32;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    mode = 5'b10000;
    logic          force_usr = 1'b0;
    logic [4*NR-1:0] raddr = '0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [3:0]    wa_a = '0, wa_b = '0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;
    logic [DW-1:0] progcount = 32'h100;

    logic [DW*NR-1:0] rdata_nb, rdata_by;
    logic             pc_wr_nb, pc_wr_by;
    logic [DW-1:0]    pc_wdata_nb, pc_wdata_by;

    always #5 clk = ~clk;

    banked_register_file #(.DATA_W(DW), .NUM_READ(NR), .BYPASS(0)) dut_nb (
        .CLK(clk), .RESET_N(rst_n), .MODE(mode), .FORCE_USR(force_usr),
        .RADDR(raddr), .RDATA(rdata_nb),
        .WE_A(we_a), .WA_A(wa_a), .WD_A(wd_a),
        .WE_B(we_b), .WA_B(wa_b), .WD_B(wd_b),
        .PROGCOUNT(progcount), .PC_WR(pc_wr_nb), .PC_WDATA(pc_wdata_nb));

    banked_register_file #(.DATA_W(DW), .NUM_READ(NR), .BYPASS(1)) dut_by (
        .CLK(clk), .RESET_N(rst_n), .MODE(mode), .FORCE_USR(force_usr),
        .RADDR(raddr), .RDATA(rdata_by),
        .WE_A(we_a), .WA_A(wa_a), .WD_A(wd_a),
        .WE_B(we_b), .WA_B(wa_b), .WD_B(wd_b),
        .PROGCOUNT(progcount), .PC_WR(pc_wr_by), .PC_WDATA(pc_wdata_by));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mem[bank][logical reg]: bank 0 = user, 1 = FIQ, 2 = IRQ, 3 = SVC.
    // Only registers that a bank actually shadows are used in banks 1..3.
    logic [DW-1:0] mem [4][15];
    logic          exp_pc_wr;
    logic [DW-1:0] exp_pc_data;

    function automatic int cur_bank();
        if (force_usr) return 0;
        case (mode)
            5'b10001: return 1;
            5'b10010: return 2;
            5'b10011: return 3;
            default:  return 0;
        endcase
    endfunction

    function automatic int owner(input int b, input logic [3:0] a);
        if (b == 1 && a >= 8) return 1;
        if ((b == 2 || b == 3) && a >= 13) return b;
        return 0;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [3:0] a, input bit byp);
        int b;
        b = cur_bank();
        if (a == 4'd15) return progcount;
        if (byp && rst_n) begin
            if (we_a && wa_a == a) return wd_a;
            if (we_b && wa_b == a) return wd_b;
        end
        return rst_n ? mem[owner(b, a)][a] : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 15; j++) mem[i][j] = '0;
        exp_pc_wr   = 1'b0;
        exp_pc_data = '0;
    endtask

    task automatic model_commit();
        int  b;
        bit  a15, b15;
        b   = cur_bank();
        a15 = we_a && wa_a == 4'd15;
        b15 = we_b && wa_b == 4'd15;
        if (we_a && !a15) mem[owner(b, wa_a)][wa_a] = wd_a;
        if (we_b && !b15 && !(we_a && wa_a == wa_b)) mem[owner(b, wa_b)][wa_b] = wd_b;
        exp_pc_wr = a15 || b15;
        if (a15)      exp_pc_data = wd_a;
        else if (b15) exp_pc_data = wd_b;
    endtask

    // ---------------- cycle helpers ----------------
    task automatic drive(input logic [4:0] m, input logic f,
                         input logic wea, input logic [3:0] waa, input logic [DW-1:0] wda,
                         input logic web, input logic [3:0] wab, input logic [DW-1:0] wdb,
                         input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
        mode = m; force_usr = f;
        we_a = wea; wa_a = waa; wd_a = wda;
        we_b = web; wa_b = wab; wd_b = wdb;
        raddr = {r2, r1, r0};
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s rd%0d nobypass", tag, k), rdata_nb[DW*k +: DW], exp_read(raddr[4*k +: 4], 1'b0));
            check($sformatf("%s rd%0d bypass", tag, k), rdata_by[DW*k +: DW], exp_read(raddr[4*k +: 4], 1'b1));
        end
    endtask

    // Called just after inputs change following a falling edge; ends at the next falling edge
    task automatic finish_cycle(input string tag);
        @(posedge clk);
        model_commit();
        #1;
        check({tag, " pc_wr nobypass"}, {31'b0, pc_wr_nb}, {31'b0, exp_pc_wr});
        check({tag, " pc_wr bypass"}, {31'b0, pc_wr_by}, {31'b0, exp_pc_wr});
        check({tag, " pc_wdata"}, pc_wdata_nb, exp_pc_data);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]    mode;
        logic          fu;
        logic          we_a;
        logic [3:0]    wa_a;
        logic [DW-1:0] wd_a;
        logic          we_b;
        logic [3:0]    wa_b;
        logic [DW-1:0] wd_b;
        logic [3:0]    ra0, ra1, ra2;
        logic [DW-1:0] e0, e1, e2;   // non-bypass reads before this row's edge
        logic          epc;          // PC_WR after this row's edge
    } vec_t;

    function automatic vec_t v(input logic [4:0] m, input logic f,
                               input logic wea, input logic [3:0] waa, input logic [DW-1:0] wda,
                               input logic web, input logic [3:0] wab, input logic [DW-1:0] wdb,
                               input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                               input logic epc);
        vec_t t;
        t.mode = m; t.fu = f; t.we_a = wea; t.wa_a = waa; t.wd_a = wda;
        t.we_b = web; t.wa_b = wab; t.wd_b = wdb;
        t.ra0 = r0; t.ra1 = r1; t.ra2 = r2; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.epc = epc;
        return t;
    endfunction

    localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                           SVC = 5'b10011, SYS = 5'b11111, ABT = 5'b10111;

    vec_t vecs [20];
    logic [4:0] mode_pool [8];

    initial begin
        model_reset();
        mode_pool = '{USR, FIQ, IRQ, SVC, SYS, ABT, 5'b11011, 5'b00000};

        //             mode fu  A: we wa   wd            B: we wa   wd          ra0   ra1   ra2   e0            e1            e2            pc
        vecs[0]  = v(USR, 0, 1, 4'd3,  32'hDEADBEEF, 0, 4'd0,  0,          4'd3, 4'd15, 4'd7, 0,            32'h100,      0,            0);
        vecs[1]  = v(USR, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd3, 4'd15, 4'd7, 32'hDEADBEEF, 32'h100,      0,            0);
        vecs[2]  = v(USR, 0, 1, 4'd13, 32'h1111,     1, 4'd7,  32'h77,     4'd13,4'd7,  4'd15,0,            0,            32'h100,      0);
        vecs[3]  = v(SVC, 0, 1, 4'd13, 32'h2222,     0, 4'd0,  0,          4'd13,4'd7,  4'd3, 0,            32'h77,       32'hDEADBEEF, 0);
        vecs[4]  = v(FIQ, 0, 1, 4'd13, 32'h3333,     0, 4'd0,  0,          4'd13,4'd7,  4'd8, 0,            32'h77,       0,            0);
        vecs[5]  = v(USR, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd7,  4'd15,32'h1111,     32'h77,       32'h100,      0);
        vecs[6]  = v(IRQ, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd7,  4'd14,0,            32'h77,       0,            0);
        vecs[7]  = v(SVC, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd7,  4'd14,32'h2222,     32'h77,       0,            0);
        vecs[8]  = v(FIQ, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd7,  4'd10,32'h3333,     32'h77,       0,            0);
        vecs[9]  = v(FIQ, 1, 1, 4'd10, 32'hA5,       0, 4'd0,  0,          4'd10,4'd13, 4'd15,0,            32'h1111,     32'h100,      0);
        vecs[10] = v(FIQ, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd10,4'd13, 4'd7, 0,            32'h3333,     32'h77,       0);
        vecs[11] = v(USR, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd10,4'd13, 4'd7, 32'hA5,       32'h1111,     32'h77,       0);
        vecs[12] = v(USR, 0, 1, 4'd4,  32'h1,        1, 4'd4,  32'h2,      4'd4, 4'd5,  4'd6, 0,            0,            0,            0);
        vecs[13] = v(USR, 0, 1, 4'd5,  32'h7,        1, 4'd6,  32'h9,      4'd4, 4'd5,  4'd6, 32'h1,        0,            0,            0);
        vecs[14] = v(USR, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd4, 4'd5,  4'd6, 32'h1,        32'h7,        32'h9,        0);
        vecs[15] = v(USR, 0, 0, 4'd0,  0,            1, 4'd15, 32'h200,    4'd15,4'd3,  4'd4, 32'h100,      32'hDEADBEEF, 32'h1,        1);
        vecs[16] = v(USR, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd15,4'd3,  4'd4, 32'h100,      32'hDEADBEEF, 32'h1,        0);
        vecs[17] = v(SYS, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd10, 4'd3, 32'h1111,     32'hA5,       32'hDEADBEEF, 0);
        vecs[18] = v(ABT, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd13,4'd8,  4'd15,32'h1111,     0,            32'h100,      0);
        vecs[19] = v(FIQ, 0, 0, 4'd0,  0,            0, 4'd0,  0,          4'd8, 4'd9,  4'd15,0,            0,            32'h100,      0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset pc_wr", {31'b0, pc_wr_nb}, 32'h0);
        check("reset pc_wdata", pc_wdata_nb, 32'h0);
        check("reset rd r0", rdata_nb[DW-1:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed sequence
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].mode, vecs[i].fu, vecs[i].we_a, vecs[i].wa_a, vecs[i].wd_a,
                  vecs[i].we_b, vecs[i].wa_b, vecs[i].wd_b, vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
            #1;
            check($sformatf("vec%0d rdata0", i), rdata_nb[DW*0 +: DW], vecs[i].e0);
            check($sformatf("vec%0d rdata1", i), rdata_nb[DW*1 +: DW], vecs[i].e1);
            check($sformatf("vec%0d rdata2", i), rdata_nb[DW*2 +: DW], vecs[i].e2);
            check_reads($sformatf("vec%0d", i));
            finish_cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d pc_wr", i), {31'b0, pc_wr_nb}, {31'b0, vecs[i].epc});
        end

        // Bypass: same-cycle write/read of R2
        drive(USR, 0, 1, 4'd2, 32'h55, 0, 4'd0, 0, 4'd2, 4'd15, 4'd4);
        #1;
        check("bypass same-cycle new", rdata_by[DW-1:0], 32'h55);
        check("nobypass same-cycle old", rdata_nb[DW-1:0], 32'h0);
        finish_cycle("bypass");
        drive(USR, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd2, 4'd15, 4'd4);
        #1;
        check("nobypass next-cycle", rdata_nb[DW-1:0], 32'h55);

        // R15 write then asynchronous reset between clock edges
        drive(USR, 0, 0, 4'd0, 0, 1, 4'd15, 32'h300, 4'd3, 4'd4, 4'd15);
        #1;
        check_reads("r15pre");
        finish_cycle("r15");
        check("r15 pulse", {31'b0, pc_wr_nb}, 32'h1);
        drive(USR, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd3, 4'd4, 4'd15);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst rd r3", rdata_nb[DW*0 +: DW], 32'h0);
        check("async rst rd r4", rdata_nb[DW*1 +: DW], 32'h0);
        check("async rst rd r15", rdata_nb[DW*2 +: DW], 32'h100);
        check("async rst pc_wr", {31'b0, pc_wr_nb}, 32'h0);
        check("async rst pc_wdata", pc_wdata_nb, 32'h0);
        we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h1234;
        #1;
        check("in-reset bypass rd", rdata_by[DW-1:0], 32'h0);
        @(posedge clk);
        #1;
        check("in-reset write ignored", rdata_nb[DW-1:0], 32'h0);
        check("in-reset pc_wr", {31'b0, pc_wr_by}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reads("post-rst");
        finish_cycle("post-rst");
        drive(USR, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd3, 4'd4, 4'd15);
        #1;
        check("first write after reset", rdata_nb[DW-1:0], 32'h1234);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rwa;
            rwa = 4'($urandom_range(0, 15));
            progcount = $urandom;
            drive(($urandom_range(0, 3) == 0) ? 5'($urandom) : mode_pool[$urandom_range(0, 6)],
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom), rwa, $urandom,
                  1'($urandom),
                  ($urandom_range(0, 3) == 0) ? rwa : 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(7, 15)), 4'($urandom_range(12, 15)));
            #1;
            check_reads($sformatf("rand%0d", n));
            finish_cycle($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
